// File: rtl/edib_m57_pkg.sv
// edib_m57_pkg: shared widths and loader FSM state encoding for the EDIB M57 frame loader.
package edib_m57_pkg;
  localparam int WORD_W = 16;
  localparam int LEN_W = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    FLUSH = 2'd3
  } state_t;
endpackage

// File: rtl/edib_sync_fifo.sv
// edib_sync_fifo: first-word-fall-through synchronous FIFO with full/empty/count.
module edib_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   Clk,
  input  logic                   Rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  // extra pointer MSB distinguishes full from empty when the index bits match
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/edib_m57_frame_loader.sv
// edib_m57_frame_loader: buffers host words into whole frames and feeds them word-by-word
// to the M57 transmitter, releasing a frame only once it is completely buffered.
module edib_m57_frame_loader
  import edib_m57_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LEN_DEPTH = 16
) (
  input  logic              Clk,
  input  logic              Rstn,
  input  logic              WrEn,
  input  logic [WORD_W-1:0] WrData,
  input  logic              FrameEnd,
  output logic              WrReady,
  output logic [WORD_W-1:0] M57In,
  output logic [LEN_W-1:0]  DataLength,
  output logic              TxStart,
  input  logic              TxDone,
  input  logic              Finished,
  input  logic              Busy,
  output logic              Active,
  output logic [7:0]        FrameCount,
  output logic              Overflow,
  output logic              SeqErr,
  input  logic              ClrErr
);
  state_t state;
  logic [WORD_W-1:0] data_head;
  logic [LEN_W-1:0] len_head, wr_len, remain, remain_nx;
  logic data_full, data_empty, len_full, len_empty;
  logic [$clog2(DEPTH):0] data_count;
  logic [$clog2(LEN_DEPTH):0] len_count;
  logic wr_push, len_push, go, data_pop, tx_take;
  assign WrReady = !data_full && !len_full;
  assign wr_push = WrEn && WrReady;
  assign len_push = wr_push && FrameEnd;
  assign FrameCount = 8'(len_count);
  assign go = !len_empty && !Busy && (LEN_W'(data_count) >= len_head);
  assign tx_take = TxDone && remain != '0;
  assign remain_nx = tx_take ? remain - 1'b1 : remain;
  assign data_pop = !data_empty && ((state == IDLE && go) || (state == SEND && tx_take) ||
                                    (state == FLUSH && remain != '0));
  edib_sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_data_fifo (
    .Clk(Clk), .Rstn(Rstn), .push(wr_push), .wdata(WrData), .pop(data_pop),
    .rdata(data_head), .full(data_full), .empty(data_empty), .count(data_count)
  );
  edib_sync_fifo #(.WIDTH(LEN_W), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .Clk(Clk), .Rstn(Rstn), .push(len_push), .wdata(wr_len + 1'b1), .pop(state == IDLE && go),
    .rdata(len_head), .full(len_full), .empty(len_empty), .count(len_count)
  );
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      wr_len <= '0;
      Overflow <= 1'b0;
    end else begin
      if (ClrErr) Overflow <= 1'b0;
      if (WrEn && !WrReady) Overflow <= 1'b1;
      if (wr_push) wr_len <= FrameEnd ? '0 : wr_len + 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      state <= IDLE;
      M57In <= '0;
      DataLength <= '0;
      TxStart <= 1'b0;
      Active <= 1'b0;
      SeqErr <= 1'b0;
      remain <= '0;
    end else begin
      TxStart <= 1'b0;
      if (ClrErr) SeqErr <= 1'b0;
      case (state)
        IDLE: if (go) begin
          DataLength <= len_head;
          M57In <= data_head;
          remain <= len_head - 1'b1;
          TxStart <= 1'b1;
          Active <= 1'b1;
          state <= START;
        end
        START: state <= SEND;
        SEND: begin
          if (tx_take) M57In <= data_head;
          if (TxDone && remain == '0) SeqErr <= 1'b1;
          remain <= remain_nx;
          // Finished is judged against the count left after this cycle's TxDone
          if (Finished && remain_nx == '0) begin
            Active <= 1'b0;
            state <= IDLE;
          end else if (Finished) begin
            SeqErr <= 1'b1;
            state <= FLUSH;
          end
        end
        FLUSH: if (remain != '0) remain <= remain - 1'b1;
        else begin
          Active <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_edib_m57_frame_loader.sv
// tb_edib_m57_frame_loader: scoreboard bench; written frames queue expected lengths/words,
// transmitter-side tasks pop and compare them as the loader presents each word.
module tb_edib_m57_frame_loader;
  logic Clk = 1'b0, Rstn = 1'b0, WrEn = 1'b0, FrameEnd = 1'b0;
  logic TxDone = 1'b0, Finished = 1'b0, Busy = 1'b0, ClrErr = 1'b0;
  logic [15:0] WrData = '0;
  logic WrReady, TxStart, Active, Overflow, SeqErr;
  logic [15:0] M57In, DataLength;
  logic [7:0] FrameCount;
  int checks = 0, errors = 0;
  logic [15:0] exp_word[$];
  int exp_len[$];

  edib_m57_frame_loader dut (
    .Clk(Clk), .Rstn(Rstn), .WrEn(WrEn), .WrData(WrData), .FrameEnd(FrameEnd),
    .WrReady(WrReady), .M57In(M57In), .DataLength(DataLength), .TxStart(TxStart),
    .TxDone(TxDone), .Finished(Finished), .Busy(Busy), .Active(Active),
    .FrameCount(FrameCount), .Overflow(Overflow), .SeqErr(SeqErr), .ClrErr(ClrErr)
  );

  always #5 Clk = ~Clk;

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d, input logic fe);
    WrEn = 1'b1;
    WrData = d;
    FrameEnd = fe;
    step;
    WrEn = 1'b0;
    FrameEnd = 1'b0;
  endtask

  task automatic write_frame(input int n, input logic [15:0] base, input logic [15:0] inc);
    for (int i = 0; i < n; i++) begin
      write_word(base + 16'(i) * inc, i == n - 1);
      exp_word.push_back(base + 16'(i) * inc);
    end
    exp_len.push_back(n);
  endtask

  task automatic wait_start;
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step;
      if (TxStart === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_timeout: TxStart=%b, required 1 within 100 cycles", TxStart);
    end
  endtask

  task automatic check_start;
    int n;
    logic [15:0] w;
    n = exp_len.size() != 0 ? exp_len.pop_front() : 0;
    w = exp_word.size() != 0 ? exp_word.pop_front() : 16'hxxxx;
    checks += 2;
    if (DataLength !== 16'(n)) begin
      errors++;
      $display("FAIL start_len: DataLength=%0d, required %0d", DataLength, n);
    end
    if (M57In !== w) begin
      errors++;
      $display("FAIL start_word: M57In=%h, required %h", M57In, w);
    end
  endtask

  task automatic tx_words(input int k);
    logic [15:0] w;
    for (int i = 0; i < k; i++) begin
      TxDone = 1'b1;
      step;
      TxDone = 1'b0;
      w = exp_word.size() != 0 ? exp_word.pop_front() : 16'hxxxx;
      checks++;
      if (M57In !== w) begin
        errors++;
        $display("FAIL tx_word %0d: M57In=%h, required %h", i, M57In, w);
      end
    end
  endtask

  task automatic finish_frame;
    Finished = 1'b1;
    step;
    Finished = 1'b0;
    checks++;
    if (Active !== 1'b0) begin
      errors++;
      $display("FAIL finish_active: Active=%b, required 0", Active);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({M57In, DataLength, TxStart, Active, FrameCount, Overflow, SeqErr, WrReady} !==
        {16'h0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s: M57In=%h DataLength=%h TxStart=%b Active=%b FrameCount=%0d Overflow=%b SeqErr=%b WrReady=%b, required 0/0/0/0/0/0/0/1",
               tag, M57In, DataLength, TxStart, Active, FrameCount, Overflow, SeqErr, WrReady);
    end
  endtask

  task automatic test_reset;
    Rstn = 1'b0;
    step;
    step;
    Rstn = 1'b1;
    exp_word.delete();
    exp_len.delete();
    check_reset_outputs("reset_state");
  endtask

  task automatic test_basic;
    write_frame(3, 16'h1111, 16'h1111);
    wait_start;
    check_start;
    step;
    checks += 2;
    if (TxStart !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: TxStart=%b, required 0", TxStart);
    end
    if (Active !== 1'b1) begin
      errors++;
      $display("FAIL basic_active: Active=%b, required 1", Active);
    end
    tx_words(2);
    finish_frame;
  endtask

  task automatic test_back_to_back;
    int starts = 0;
    Busy = 1'b1;
    write_frame(2, 16'hA000, 16'h0001);
    write_frame(5, 16'hB000, 16'h0001);
    step;
    checks++;
    if (FrameCount !== 8'd2) begin
      errors++;
      $display("FAIL b2b_count: FrameCount=%0d, required 2", FrameCount);
    end
    Busy = 1'b0;
    wait_start;
    check_start;
    checks++;
    if (FrameCount !== 8'd1) begin
      errors++;
      $display("FAIL b2b_count_after: FrameCount=%0d, required 1", FrameCount);
    end
    step;
    tx_words(1);
    Busy = 1'b1;
    finish_frame;
    for (int i = 0; i < 5; i++) begin
      step;
      if (TxStart === 1'b1) starts++;
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL b2b_busy_hold: %0d starts while Busy, required 0", starts);
    end
    Busy = 1'b0;
    wait_start;
    check_start;
    step;
    tx_words(4);
    finish_frame;
  endtask

  task automatic test_seq_err;
    Busy = 1'b1;
    write_frame(4, 16'hC000, 16'h0010);
    write_frame(2, 16'hD000, 16'h0010);
    Busy = 1'b0;
    wait_start;
    check_start;
    step;
    tx_words(2);
    Finished = 1'b1;
    step;
    Finished = 1'b0;
    checks++;
    if (SeqErr !== 1'b1) begin
      errors++;
      $display("FAIL seq_err_set: SeqErr=%b, required 1", SeqErr);
    end
    void'(exp_word.pop_front());
    wait_start;
    check_start;
    step;
    tx_words(1);
    finish_frame;
    ClrErr = 1'b1;
    step;
    ClrErr = 1'b0;
    checks++;
    if (SeqErr !== 1'b0) begin
      errors++;
      $display("FAIL seq_err_clear: SeqErr=%b, required 0", SeqErr);
    end
  endtask

  task automatic test_partial;
    int starts = 0;
    test_reset;
    write_word(16'h0101, 1'b0);
    write_word(16'h0202, 1'b0);
    write_word(16'h0303, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step;
      if (TxStart === 1'b1) starts++;
    end
    checks += 2;
    if (starts != 0) begin
      errors++;
      $display("FAIL partial_start: %0d starts, required 0", starts);
    end
    if (FrameCount !== 8'd0) begin
      errors++;
      $display("FAIL partial_count: FrameCount=%0d, required 0", FrameCount);
    end
  endtask

  task automatic test_overflow;
    test_reset;
    for (int i = 0; i < 1024; i++) write_word(16'(i), 1'b0);
    checks += 2;
    if (WrReady !== 1'b0) begin
      errors++;
      $display("FAIL ovf_ready: WrReady=%b, required 0", WrReady);
    end
    if (Overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: Overflow=%b, required 0", Overflow);
    end
    write_word(16'hDEAD, 1'b1);
    checks += 2;
    if (Overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: Overflow=%b, required 1", Overflow);
    end
    if (FrameCount !== 8'd0) begin
      errors++;
      $display("FAIL ovf_count: FrameCount=%0d, required 0", FrameCount);
    end
    ClrErr = 1'b1;
    step;
    ClrErr = 1'b0;
    checks++;
    if (Overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: Overflow=%b, required 0", Overflow);
    end
  endtask

  task automatic test_reset_mid;
    test_reset;
    write_frame(8, 16'hE000, 16'h0003);
    wait_start;
    check_start;
    step;
    tx_words(2);
    Rstn = 1'b0;
    step;
    Rstn = 1'b1;
    exp_word.delete();
    exp_len.delete();
    check_reset_outputs("reset_mid");
    write_frame(1, 16'hF00D, 16'h0000);
    wait_start;
    check_start;
    step;
    finish_frame;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_seq_err;
    test_partial;
    test_overflow;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
